// File: rtl/hex_byte_asm.sv
// Intel-HEX character-to-byte assembler: pairs hex digits into bytes, tags each
// byte with its record field and checks the record checksum.
module hex_byte_asm #(
    parameter bit ALLOW_LOWER = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] CH_IN,
    input  logic       CH_VALID,
    output logic       CH_READY,
    output logic [7:0] BYTE_OUT,
    output logic       BYTE_VALID,
    input  logic       BYTE_READY,
    output logic [2:0] BYTE_KIND,
    output logic [7:0] BYTE_IDX,
    output logic       REC_END,
    output logic       CHK_ERR,
    output logic       FMT_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;
    typedef enum logic [2:0] {
        K_LEN     = 3'd0,
        K_ADDR_HI = 3'd1,
        K_ADDR_LO = 3'd2,
        K_TYPE    = 3'd3,
        K_DATA    = 3'd4,
        K_CHK     = 3'd5
    } kind_t;

    state_t     state, state_d;
    kind_t      field;
    logic [3:0] hi_nib;
    logic [3:0] nib;
    logic       is_hex, is_colon, is_ws;
    logic [7:0] sum, len, data_cnt;
    logic [7:0] new_byte, sum_next;
    logic       accept;
    logic       do_hi, do_load, do_restart, do_fmt;

    assign CH_READY = !(BYTE_VALID && !BYTE_READY);
    assign accept   = CH_VALID && CH_READY;
    assign new_byte = {hi_nib, nib};
    assign sum_next = sum + new_byte;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        is_hex   = 1'b0;
        nib      = 4'd0;
        is_colon = (CH_IN == 8'h3A);
        is_ws    = (CH_IN == 8'h0D) || (CH_IN == 8'h0A) || (CH_IN == 8'h20);
        if (CH_IN >= 8'h30 && CH_IN <= 8'h39) begin
            is_hex = 1'b1;
            nib    = CH_IN[3:0];
        end else if (CH_IN >= 8'h41 && CH_IN <= 8'h46) begin
            is_hex = 1'b1;
            nib    = CH_IN[3:0] + 4'd9;
        end else if (ALLOW_LOWER && CH_IN >= 8'h61 && CH_IN <= 8'h66) begin
            is_hex = 1'b1;
            nib    = CH_IN[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_d    = state;
        do_hi      = 1'b0;
        do_load    = 1'b0;
        do_restart = 1'b0;
        do_fmt     = 1'b0;
        if (accept) begin
            unique case (state)
                S_IDLE: begin
                    if (is_colon) begin
                        do_restart = 1'b1;
                        state_d    = S_HI;
                    end else if (!is_ws) begin
                        do_fmt = 1'b1;
                    end
                end
                S_HI, S_LO: begin
                    if (is_hex) begin
                        if (state == S_HI) begin
                            do_hi   = 1'b1;
                            state_d = S_LO;
                        end else begin
                            do_load = 1'b1;
                            state_d = (field == K_CHK) ? S_IDLE : S_HI;
                        end
                    end else if (is_colon) begin
                        // A stray ':' inside a record is treated as the start of a fresh one.
                        do_fmt     = 1'b1;
                        do_restart = 1'b1;
                        state_d    = S_HI;
                    end else begin
                        do_fmt  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            BYTE_OUT   <= 8'd0;
            BYTE_VALID <= 1'b0;
            BYTE_KIND  <= 3'd0;
            BYTE_IDX   <= 8'd0;
            REC_END    <= 1'b0;
            CHK_ERR    <= 1'b0;
            FMT_ERR    <= 1'b0;
            field      <= K_LEN;
            hi_nib     <= 4'd0;
            sum        <= 8'd0;
            len        <= 8'd0;
            data_cnt   <= 8'd0;
        end else begin
            REC_END <= 1'b0;
            CHK_ERR <= 1'b0;
            FMT_ERR <= do_fmt;
            if (BYTE_VALID && BYTE_READY) BYTE_VALID <= 1'b0;
            if (do_hi) hi_nib <= nib;
            if (do_restart) begin
                field    <= K_LEN;
                sum      <= 8'd0;
                data_cnt <= 8'd0;
            end
            if (do_load) begin
                BYTE_VALID <= 1'b1;
                BYTE_OUT   <= new_byte;
                BYTE_KIND  <= field;
                BYTE_IDX   <= (field == K_DATA) ? data_cnt : 8'd0;
                sum        <= sum_next;
                unique case (field)
                    K_LEN: begin
                        len   <= new_byte;
                        field <= K_ADDR_HI;
                    end
                    K_ADDR_HI: field <= K_ADDR_LO;
                    K_ADDR_LO: field <= K_TYPE;
                    K_TYPE: begin
                        data_cnt <= 8'd0;
                        field    <= (len == 8'd0) ? K_CHK : K_DATA;
                    end
                    K_DATA: begin
                        data_cnt <= data_cnt + 8'd1;
                        if (data_cnt == len - 8'd1) field <= K_CHK;
                    end
                    K_CHK: begin
                        REC_END <= 1'b1;
                        CHK_ERR <= (sum_next != 8'd0);
                        field   <= K_LEN;
                    end
                    default: field <= K_LEN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_byte_asm.sv
// Directed bench for hex_byte_asm: one instance accepts lowercase, one rejects it;
// both share the same character stream.
module tb_hex_byte_asm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] CH_IN;
    logic       CH_VALID;
    logic       BYTE_READY;

    logic       a_ch_ready, a_byte_valid, a_rec_end, a_chk_err, a_fmt_err;
    logic [7:0] a_byte_out, a_byte_idx;
    logic [2:0] a_byte_kind;
    logic       b_ch_ready, b_byte_valid, b_rec_end, b_chk_err, b_fmt_err;
    logic [7:0] b_byte_out, b_byte_idx;
    logic [2:0] b_byte_kind;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    hex_byte_asm #(.ALLOW_LOWER(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .CH_IN(CH_IN), .CH_VALID(CH_VALID), .CH_READY(a_ch_ready),
        .BYTE_OUT(a_byte_out), .BYTE_VALID(a_byte_valid), .BYTE_READY(BYTE_READY),
        .BYTE_KIND(a_byte_kind), .BYTE_IDX(a_byte_idx), .REC_END(a_rec_end),
        .CHK_ERR(a_chk_err), .FMT_ERR(a_fmt_err)
    );

    hex_byte_asm #(.ALLOW_LOWER(1'b0)) dut_b (
        .CLK(CLK), .RST(RST), .CH_IN(CH_IN), .CH_VALID(CH_VALID), .CH_READY(b_ch_ready),
        .BYTE_OUT(b_byte_out), .BYTE_VALID(b_byte_valid), .BYTE_READY(BYTE_READY),
        .BYTE_KIND(b_byte_kind), .BYTE_IDX(b_byte_idx), .REC_END(b_rec_end),
        .CHK_ERR(b_chk_err), .FMT_ERR(b_fmt_err)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one character and returns #1 after the edge that accepted it.
    task automatic send(input logic [7:0] c);
        int n = 0;
        CH_IN    = c;
        CH_VALID = 1'b1;
        #0;
        while (!a_ch_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("ch_ready_wait", {15'd0, a_ch_ready}, 16'd1);
        @(posedge CLK); #1;
        CH_VALID = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic [2:0] k, input logic [7:0] idx,
                               input logic e, input logic ce);
        check("valid",   {15'd0, a_byte_valid}, 16'd1);
        check("out",     {8'd0, a_byte_out}, {8'd0, b});
        check("out_b",   {8'd0, b_byte_out}, {8'd0, b});
        check("kind",    {13'd0, a_byte_kind}, {13'd0, k});
        check("idx",     {8'd0, a_byte_idx}, {8'd0, idx});
        check("rec_end", {15'd0, a_rec_end}, {15'd0, e});
        check("chk_err", {15'd0, a_chk_err}, {15'd0, ce});
        check("fmt_err", {15'd0, a_fmt_err}, 16'd0);
    endtask

    task automatic send_pair(input logic [7:0] h, input logic [7:0] l, input logic [7:0] b,
                             input logic [2:0] k, input logic [7:0] idx,
                             input logic e, input logic ce);
        send(h);
        check("hi_no_byte", {15'd0, a_byte_valid}, 16'd0);
        send(l);
        expect_byte(b, k, idx, e, ce);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {a_byte_out, 5'd0, a_byte_kind}, 16'd0);
        check(tag, {a_byte_idx, 4'd0, a_byte_valid, a_rec_end, a_chk_err, a_fmt_err}, 16'd0);
        check(tag, {b_byte_out, 4'd0, b_byte_valid, b_rec_end, b_chk_err, b_fmt_err}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; CH_IN = 8'h00; CH_VALID = 1'b0; BYTE_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_zero("reset");
        check("reset_ready", {15'd0, a_ch_ready}, 16'd1);

        // :0300300002337A1E
        send(":");
        check("colon_no_byte", {15'd0, a_byte_valid}, 16'd0);
        send_pair("0", "3", 8'h03, 3'd0, 8'd0, 1'b0, 1'b0);
        send_pair("0", "0", 8'h00, 3'd1, 8'd0, 1'b0, 1'b0);
        send_pair("3", "0", 8'h30, 3'd2, 8'd0, 1'b0, 1'b0);
        send_pair("0", "0", 8'h00, 3'd3, 8'd0, 1'b0, 1'b0);
        send_pair("0", "2", 8'h02, 3'd4, 8'd0, 1'b0, 1'b0);
        send_pair("3", "3", 8'h33, 3'd4, 8'd1, 1'b0, 1'b0);
        send_pair("7", "A", 8'h7A, 3'd4, 8'd2, 1'b0, 1'b0);
        send_pair("1", "E", 8'h1E, 3'd5, 8'd0, 1'b1, 1'b0);
        @(posedge CLK); #1;
        check("rec_end_pulse", {15'd0, a_rec_end}, 16'd0);

        // :00000001FF\r\n
        send(":");
        send_pair("0", "0", 8'h00, 3'd0, 8'd0, 1'b0, 1'b0);
        send_pair("0", "0", 8'h00, 3'd1, 8'd0, 1'b0, 1'b0);
        send_pair("0", "0", 8'h00, 3'd2, 8'd0, 1'b0, 1'b0);
        send_pair("0", "1", 8'h01, 3'd3, 8'd0, 1'b0, 1'b0);
        send_pair("F", "F", 8'hFF, 3'd5, 8'd0, 1'b1, 1'b0);
        send(8'h0D);
        check("cr_fmt", {15'd0, a_fmt_err}, 16'd0);
        send(8'h0A);
        check("lf_fmt", {14'd0, a_fmt_err, b_fmt_err}, 16'd0);

        // :00000001FE -> bad checksum
        send(":");
        send_pair("0", "0", 8'h00, 3'd0, 8'd0, 1'b0, 1'b0);
        send_pair("0", "0", 8'h00, 3'd1, 8'd0, 1'b0, 1'b0);
        send_pair("0", "0", 8'h00, 3'd2, 8'd0, 1'b0, 1'b0);
        send_pair("0", "1", 8'h01, 3'd3, 8'd0, 1'b0, 1'b0);
        send_pair("F", "E", 8'hFE, 3'd5, 8'd0, 1'b1, 1'b1);

        // Backpressure on the LEN byte of ":0300..."
        send(":");
        send_pair("0", "3", 8'h03, 3'd0, 8'd0, 1'b0, 1'b0);
        BYTE_READY = 1'b0;
        CH_IN      = "0";
        CH_VALID   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("bp_ready", {15'd0, a_ch_ready}, 16'd0);
            check("bp_hold", {7'd0, a_byte_valid, a_byte_out}, 16'h0103);
        end
        BYTE_READY = 1'b1;
        #1;
        check("bp_release", {15'd0, a_ch_ready}, 16'd1);
        @(posedge CLK); #1;
        CH_VALID = 1'b0;
        check("bp_retire", {15'd0, a_byte_valid}, 16'd0);
        send("0");
        expect_byte(8'h00, 3'd1, 8'd0, 1'b0, 1'b0);

        // Reset mid-record, then a clean record
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_zero("mid_reset");
        send(":");
        send_pair("0", "0", 8'h00, 3'd0, 8'd0, 1'b0, 1'b0);
        send_pair("0", "0", 8'h00, 3'd1, 8'd0, 1'b0, 1'b0);
        send_pair("0", "0", 8'h00, 3'd2, 8'd0, 1'b0, 1'b0);
        send_pair("0", "1", 8'h01, 3'd3, 8'd0, 1'b0, 1'b0);
        send_pair("F", "F", 8'hFF, 3'd5, 8'd0, 1'b1, 1'b0);

        // ":0a" accepted by dut_a, rejected by dut_b
        send(":");
        send("0");
        send("a");
        check("lower_a_byte", {7'd0, a_byte_valid, a_byte_out}, 16'h010A);
        check("lower_a_kind", {12'd0, a_fmt_err, a_byte_kind}, 16'd0);
        check("lower_b_fmt", {14'd0, b_fmt_err, b_byte_valid}, 16'b10);
        @(posedge CLK); #1;
        check("lower_b_pulse", {15'd0, b_fmt_err}, 16'd0);
        send("X");
        check("x_fmt", {14'd0, a_fmt_err, b_fmt_err}, 16'b11);
        check("x_no_byte", {14'd0, a_byte_valid, b_byte_valid}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
